// File: rtl/cz_intc_pkg.sv
// Shared definitions for the cz interrupt controller: register offsets,
// controller state encoding and STATUS register layout.
package cz_intc_pkg;

    localparam logic [2:0] OFS_ENABLE = 3'd0;
    localparam logic [2:0] OFS_MODE   = 3'd1;
    localparam logic [2:0] OFS_PEND   = 3'd2;
    localparam logic [2:0] OFS_STATUS = 3'd3;
    localparam logic [2:0] OFS_EOI    = 3'd4;

    localparam int STAT_IN_SERVICE = 7;
    localparam int STAT_SPURIOUS   = 6;
    localparam int STAT_VEC_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intcState_t;

    // Fixed priority: the lowest set index wins.
    function automatic logic [2:0] lowestSet(input logic [7:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cz_intc_chan.sv
// One interrupt channel: input synchroniser, rising-edge detector and
// edge pending latch; level channels report the synchronised input directly.
module cz_intc_chan
    import cz_intc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic edgeMode,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] syncSh;
    logic [SYNC_STAGES-1:0] primeSh;
    logic                   s;
    logic                   prev;
    logic                   edgePend;

    assign s = syncSh[SYNC_STAGES-1];

    // The edge history is held at 1 until the synchroniser has refilled after
    // reset, so a source that was already high is never seen as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncSh   <= '0;
            primeSh  <= '0;
            prev     <= 1'b1;
            edgePend <= 1'b0;
        end else begin
            syncSh  <= {syncSh[SYNC_STAGES-2:0], irq};
            primeSh <= {primeSh[SYNC_STAGES-2:0], 1'b1};
            if (primeSh[SYNC_STAGES-1]) prev <= s;
            if (s && !prev) begin
                edgePend <= 1'b1;
            end else if (clr) begin
                edgePend <= 1'b0;
            end
        end
    end

    assign pending = edgeMode ? edgePend : s;

endmodule

// File: rtl/cz_intc.sv
// cz interrupt controller: NUM_INT channels with enable/mode registers, a
// fixed-priority request to the core and a port-bus register window.
module cz_intc
    import cz_intc_pkg::*;
#(
    parameter int         NUM_INT     = 8,
    parameter logic [7:0] BASE_ADDR   = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               xRESET_P,
    input  logic [NUM_INT-1:0] xIRQ_P,
    input  logic [7:0]         xPORTID_P,
    input  logic [7:0]         xOUTPORT_P,
    input  logic               xWSTROBE_P,
    input  logic               xRSTROBE_P,
    output logic [7:0]         xRDATA_P,
    output logic               xRSEL_P,
    output logic               xINT_P,
    input  logic               xINTACK_P,
    output logic [2:0]         xVEC_P
);

    localparam logic [7:0] INT_MASK = 8'((16'd1 << NUM_INT) - 16'd1);

    intcState_t state;
    logic [7:0] enableReg;
    logic [7:0] modeReg;
    logic [7:0] pending;
    logic [7:0] active;
    logic [7:0] pendW1c;
    logic [7:0] ackClr;
    logic [7:0] statusVal;
    logic [2:0] offs;
    logic [2:0] winner;
    logic       wrEn;
    logic       req;
    logic       ackTake;
    logic       inService;
    logic       spurious;
    logic       unusedRstrobe;

    // Reads have no side effects, so the read strobe is not needed.
    assign unusedRstrobe = xRSTROBE_P;

    assign xRSEL_P = (xPORTID_P[7:3] == BASE_ADDR[7:3]);
    assign offs    = xPORTID_P[2:0];
    assign wrEn    = xWSTROBE_P && xRSEL_P;

    assign active  = pending & enableReg;
    assign req     = |active;
    assign winner  = lowestSet(active);
    assign ackTake = (state == ST_REQ) && xINTACK_P && req;
    assign ackClr  = ackTake ? ((8'd1 << winner) & modeReg) : 8'd0;
    assign pendW1c = (wrEn && offs == OFS_PEND) ? (xOUTPORT_P & INT_MASK) : 8'd0;

    for (genvar i = 0; i < 8; i++) begin : gChan
        if (i < NUM_INT) begin : gLive
            cz_intc_chan #(
                .SYNC_STAGES(SYNC_STAGES)
            ) uChan (
                .clk     (CLK),
                .rst     (xRESET_P),
                .irq     (xIRQ_P[i]),
                .edgeMode(modeReg[i]),
                .clr     (pendW1c[i] | ackClr[i]),
                .pending (pending[i])
            );
        end else begin : gTie
            assign pending[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (xRESET_P) begin
            state     <= ST_IDLE;
            enableReg <= 8'd0;
            modeReg   <= 8'd0;
            inService <= 1'b0;
            spurious  <= 1'b0;
            xINT_P    <= 1'b0;
            xVEC_P    <= 3'd0;
        end else begin
            if (wrEn && offs == OFS_ENABLE) enableReg <= xOUTPORT_P & INT_MASK;
            if (wrEn && offs == OFS_MODE)   modeReg   <= xOUTPORT_P & INT_MASK;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state  <= ST_REQ;
                        xINT_P <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (xINTACK_P) begin
                        xINT_P <= 1'b0;
                        if (req) begin
                            xVEC_P    <= winner;
                            inService <= 1'b1;
                            spurious  <= 1'b0;
                            state     <= ST_SERVICE;
                        end else begin
                            xVEC_P   <= 3'd0;
                            spurious <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end else if (!req) begin
                        xINT_P <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (wrEn && offs == OFS_EOI) begin
                        inService <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    xINT_P <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        statusVal                    = 8'd0;
        statusVal[STAT_IN_SERVICE]   = inService;
        statusVal[STAT_SPURIOUS]     = spurious;
        statusVal[STAT_VEC_LSB+:3]   = xVEC_P;
    end

    always_comb begin
        xRDATA_P = 8'd0;
        if (xRSEL_P) begin
            case (offs)
                OFS_ENABLE: xRDATA_P = enableReg;
                OFS_MODE:   xRDATA_P = modeReg;
                OFS_PEND:   xRDATA_P = pending;
                OFS_STATUS: xRDATA_P = statusVal;
                default:    xRDATA_P = 8'd0;
            endcase
        end
    end

endmodule

// File: doc/cz_intc.md
Name: cz_intc

Overview:
- Parametrised interrupt controller for the cz core family. It generalises the two fixed raw interrupt pins to NUM_INT channels.
- Per channel: input synchroniser, edge/level mode, enable mask and pending latch. A fixed-priority encoder (lowest index wins) feeds a single request/acknowledge handshake with the core.
- Software programs it through the core's existing port bus: PORTID, OUTPORT, WSTROBE and RSTROBE.

Parameters:
- NUM_INT, 8, number of interrupt channels, legal range 1..8.
- BASE_ADDR, 8'hF0, port address of register 0; the register window is BASE_ADDR..BASE_ADDR+4; BASE_ADDR[2:0] must be 0.
- SYNC_STAGES, 2, synchroniser flops per input, minimum 2.

Ports:
- CLK  in  1  single clock.
- xRESET_P  in  1  reset; synchronous, active-high.
- xIRQ_P  in  NUM_INT  asynchronous interrupt sources.
- xPORTID_P  in  8  port address from core.
- xOUTPORT_P  in  8  write data from core.
- xWSTROBE_P  in  1  write strobe, one cycle.
- xRSTROBE_P  in  1  read strobe, one cycle.
- xRDATA_P  out  8  read data, combinational from PORTID.
- xRSEL_P  out  1  high when PORTID is inside the window; gates the core's input mux.
- xINT_P  out  1  registered interrupt request to core.
- xINTACK_P  in  1  one-cycle acknowledge from core.
- xVEC_P  out  3  registered vector of the request in service.

Behaviour:
- Clock/reset: one clock, CLK. xRESET_P is synchronous and active-high; it takes effect on the CLK rising edge.
- Register map (offset from BASE_ADDR):
  - +0 ENABLE, R/W, reset 0.
  - +1 MODE, R/W, 1 = rising edge, 0 = level, reset 0.
  - +2 PENDING: read returns pending; write-1-to-clear (edge channels only).
  - +3 STATUS, RO: {in_service, spurious, 3'b0, vec[2:0]}.
  - +4 EOI: any write ends service.
  - Bits at and above NUM_INT read 0 and ignore writes. Offsets +5..+7 read 0 and ignore writes; xRSEL_P is still high for them.
- Reset values:
  - All registers, pending and state cleared; xINT_P=0, xVEC_P=0, state IDLE.
  - Synchroniser flops reset to 0. Edge-history flops reset to all 1s, so an input already high at reset release is not an edge.
- Synchroniser: each input passes through SYNC_STAGES flops to give s[i].
- Pending, edge channel:
  - Set on s[i]=1 with prev[i]=0, independent of ENABLE.
  - Cleared by a W1C write or by acknowledge of that channel.
  - A set on the same cycle as a clear: set wins.
- Pending, level channel: pending[i] = s[i]. Writes have no effect.
- Request: req = |(pending & ENABLE). The winner is the lowest set index.
- Latency: an input rising edge (held ≥ 1 cycle past sampling) gives pending 1 after SYNC_STAGES+1 edges and xINT_P 1 on the following edge. For SYNC_STAGES=2 that is 4 cycles.
- FSM (IDLE, REQ, SERVICE):
  - IDLE: when req=1, go to REQ with xINT_P←1.
  - REQ: xINT_P stays 1. If req drops before ack (level source released, W1C, or mask), go to IDLE with xINT_P←0. On xINTACK_P=1:
    - If req still 1: latch xVEC_P←winner, clear the winner's pending if it is an edge channel, set in_service, xINT_P←0, go to SERVICE.
    - If req is 0 in the same cycle: set spurious, xVEC_P←0, go to IDLE.
  - SERVICE: xINT_P=0 and no nesting. A write to EOI clears in_service and goes to IDLE. A new request can assert xINT_P at the earliest one cycle later.
  - xINTACK_P in IDLE or SERVICE is ignored.
  - spurious clears on the next acknowledge that has a valid winner, or on reset.
- Masking: clearing ENABLE while in SERVICE does not end service.
- Reset mid-operation: reset in any state returns everything to the reset values on that edge. Pending edges are lost.
- Simultaneous write to ENABLE and acknowledge: the acknowledge uses the pre-write ENABLE.

Decomposition:
- Package cz_intc_pkg holds:
  - register offsets (OFS_ENABLE=0, OFS_MODE=1, OFS_PEND=2, OFS_STATUS=3, OFS_EOI=4);
  - the FSM state encoding;
  - STATUS bit positions.
- One sub-module, cz_intc_chan: a single-channel synchroniser, edge detect and pending latch, instantiated NUM_INT times with generate.

Test Plan:
- Reset, then write ENABLE=0x04, MODE=0x04, pulse xIRQ_P[2] for 1 cycle -> xINT_P=1 exactly 4 cycles later. Ack -> xVEC_P=2, PENDING=0x00, STATUS=0x82. EOI -> STATUS=0x02 (vec retained), xINT_P=0.
- ENABLE=0xFF, MODE=0xFF, raise IRQ 1, 5, 6 in the same cycle -> ack vector 1. After EOI the next ack gives 5, then 6; PENDING reads 0x60, then 0x40, then 0x00.
- Level channel 3 (MODE bit 3=0, ENABLE=0x08): hold IRQ3 high, ack, EOI -> xINT_P reasserts 1 cycle after EOI. W1C to PENDING=0x08 has no effect. Drop IRQ3 while in REQ -> xINT_P=0 within SYNC_STAGES+1 cycles.
- Edge on a masked channel 0 (ENABLE=0) -> PENDING=0x01, xINT_P stays 0. Write ENABLE=0x01 -> xINT_P=1 after 2 cycles. W1C of 0x01 on the same cycle as a new edge -> PENDING stays 0x01.
- Level IRQ4 drops on the same cycle xINTACK_P arrives -> STATUS=0x40, xVEC_P=0, state IDLE. Next valid ack clears the spurious bit.
- Assert xRESET_P one cycle while in SERVICE -> all registers 0, xINT_P=0, xRSEL_P=1 for PORTID=0xF7, reads 0x00. An IRQ held high through reset causes no edge pending.
